inst_fetch_unit: RTL and testbench

Front-end stage directly upstream of the MIPS control decoder. It owns the PC and fetches words from instruction memory over a req/ack handshake. It presents one instruction at a time to the decoder and datapath. On retire it computes the next PC from the decoder's o_J/o_Jr/o_Beq/o_Bne outputs, the ALU zero flag and the held instruction.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/inst_fetch_unit_if.sv | 10 +
 rtl/next_pc_calc.sv | 38 +++
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode/funct encodings, fetch FSM states,
// default reset PC and the branch offset helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    HALT
  } fetch_state_t;

  // Sign-extended 16-bit immediate, scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory req/ack bus: the fetch unit is the master, memory the slave.
interface inst_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational control-transfer resolution for the held instruction.
// Priority is Jr > J > taken branch; only a Jr target can be misaligned.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst_index,
  input  logic        j,
  input  logic        jr,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] p4,
  output logic [31:0] target,
  output logic        taken,
  output logic        misalign
);

  always_comb begin
    p4       = pc + 32'd4;
    target   = p4;
    taken    = 1'b0;
    misalign = 1'b0;
    if (jr) begin
      target   = jr_target;
      taken    = 1'b1;
      misalign = |jr_target[1:0];
    end else if (j) begin
      target = {p4[31:28], inst_index, 2'b00};
      taken  = 1'b1;
    end else if ((beq && zero) || (bne && !zero)) begin
      target = p4 + branch_offset(inst_index[15:0]);
      taken  = 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC owner and single-instruction fetch FSM (FETCH -> ISSUE -> FETCH, HALT on fault).
// Define MIPS_DELAY_SLOT_EN for an architectural branch delay slot.
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  inst_fetch_unit_if.master     imem,
  output logic [31:0]           o_inst,
  output logic                  o_inst_valid,
  output logic [ADDR_W-1:0]     o_pc,
  input  logic                  i_stall,
  input  logic                  i_J,
  input  logic                  i_Jr,
  input  logic                  i_Beq,
  input  logic                  i_Bne,
  input  logic                  i_zero,
  input  logic [31:0]           i_jr_target,
  output logic                  o_fault
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       inst_reg;
  logic              valid_reg;
  logic              req_reg;
  logic              fault_reg;

  logic [31:0] p4;
  logic [31:0] xfer_target;
  logic        xfer_taken;
  logic        xfer_misalign;
  logic [31:0] pc_next;
  logic        fault_now;

  next_pc_calc u_next_pc_calc (
    .pc         (pc_reg),
    .inst_index (inst_reg[25:0]),
    .j          (i_J),
    .jr         (i_Jr),
    .beq        (i_Beq),
    .bne        (i_Bne),
    .zero       (i_zero),
    .jr_target  (i_jr_target),
    .p4         (p4),
    .target     (xfer_target),
    .taken      (xfer_taken),
    .misalign   (xfer_misalign)
  );

`ifdef MIPS_DELAY_SLOT_EN
  logic        pend_reg;
  logic [31:0] pend_pc_reg;

  // The delay-slot instruction's own control is ignored; it just releases pend_pc.
  always_comb begin
    fault_now = !pend_reg && xfer_misalign;
    pc_next   = pend_reg ? pend_pc_reg : p4;
  end
`else
  always_comb begin
    fault_now = xfer_misalign;
    pc_next   = xfer_taken ? xfer_target : p4;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      inst_reg    <= '0;
      valid_reg   <= 1'b0;
      req_reg     <= 1'b0;
      fault_reg   <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
`endif
    end else begin
      case (state_reg)
        FETCH: begin
          // First cycle out of reset raises req; ack only counts once req is up.
          if (!req_reg) begin
            req_reg <= 1'b1;
          end else if (imem.ack) begin
            inst_reg  <= imem.rdata;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i_stall) begin
            valid_reg <= 1'b0;
            if (fault_now) begin
              fault_reg <= 1'b1;
              state_reg <= HALT;
            end else begin
              pc_reg    <= pc_next;
              req_reg   <= 1'b1;
              state_reg <= FETCH;
`ifdef MIPS_DELAY_SLOT_EN
              if (pend_reg) begin
                pend_reg <= 1'b0;
              end else if (xfer_taken) begin
                pend_reg    <= 1'b1;
                pend_pc_reg <= xfer_target;
              end
`endif
            end
          end
        end
        HALT: begin
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
        default: begin
          state_reg <= HALT;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
          fault_reg <= 1'b1;
        end
      endcase
    end
  end

  assign imem.req     = req_reg;
  assign imem.addr    = pc_reg;
  assign o_inst       = inst_reg;
  assign o_inst_valid = valid_reg;
  assign o_pc         = pc_reg;
  assign o_fault      = fault_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fetch order, branch/jump targets, stalls,
// mid-fetch reset and misaligned-Jr halt (delay-slot flow when the macro is set).
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic [31:0] o_pc;
  logic        stall = 1'b0;
  logic        j = 1'b0, jr = 1'b0, beq = 1'b0, bne = 1'b0, zero = 1'b0;
  logic [31:0] jr_target = '0;
  logic        o_fault;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if imem();

  inst_fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .imem         (imem),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .o_pc         (o_pc),
    .i_stall      (stall),
    .i_J          (j),
    .i_Jr         (jr),
    .i_Beq        (beq),
    .i_Bne        (bne),
    .i_zero       (zero),
    .i_jr_target  (jr_target),
    .o_fault      (o_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] jr_inst();
    return {OP_RTYPE, 5'd1, 15'd0, FUNCT_JR};
  endfunction

  // Wait (bounded) for req, hold off ack for 'waits' cycles, then deliver 'word'.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                          input int lat, input int waits);
    int n;
    n = 0;
    while (!imem.req && n < 8) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_addr"}, imem.addr, addr);
    for (int i = 0; i < waits; i++) step();
    if (waits > 0) begin
      check({tag, "_addr_hold"}, imem.addr, addr);
      check({tag, "_req_hold"}, {31'd0, imem.req}, 32'd1);
      check({tag, "_valid_wait"}, {31'd0, o_inst_valid}, 32'd0);
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    step();
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
    check({tag, "_valid"}, {31'd0, o_inst_valid}, 32'd1);
    check({tag, "_inst"}, o_inst, word);
    check({tag, "_pc"}, o_pc, addr);
    check({tag, "_req_low"}, {31'd0, imem.req}, 32'd0);
  endtask

  // ctl = {jr, j, beq, bne}; retires in the next edge (no stall).
  task automatic retire(input logic [3:0] ctl, input logic z, input logic [31:0] tgt);
    {jr, j, beq, bne} = ctl;
    zero      = z;
    jr_target = tgt;
    step();
    {jr, j, beq, bne} = 4'b0000;
    zero      = 1'b0;
    jr_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    imem.ack   = 1'b0;
    imem.rdata = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    check("rst_fault", {31'd0, o_fault}, 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_inst", o_inst, 32'h0);

`ifdef MIPS_DELAY_SLOT_EN
    do_fetch("ds_f0", 32'h0, 32'h0, 1, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("ds_f4", 32'h4, 32'h0, 0, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("ds_j", 32'h8, j_type(OP_J, 26'h40), 0, 0);
    retire(4'b0100, 1'b0, '0);
    do_fetch("ds_slot", 32'hC, i_type(OP_BEQ, 16'h0010), 0, 0);
    retire(4'b0010, 1'b1, '0);
    do_fetch("ds_tgt", 32'h100, jr_inst(), 0, 0);
    retire(4'b1000, 1'b0, 32'h202);
    check("ds_fault", {31'd0, o_fault}, 32'd1);
    check("ds_fault_req", {31'd0, imem.req}, 32'd0);
`else
    // Zero-wait sequential fetch: two cycles per instruction.
    do_fetch("f0", 32'h0, 32'h0, 1, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("f4", 32'h4, 32'h0, 0, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("f8", 32'h8, 32'h0, 0, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("fC", 32'hC, 32'h0, 0, 0);
    retire(4'b0000, 1'b0, '0);
    check("seq_fault", {31'd0, o_fault}, 32'd0);

    // Branches: BEQ -4 taken, BNE +8 taken, BEQ not taken.
    do_fetch("beq_t", 32'h10, i_type(OP_BEQ, 16'hFFFF), 0, 0);
    retire(4'b0010, 1'b1, '0);
    do_fetch("bne_t", 32'h10, i_type(OP_BNE, 16'h0002), 0, 0);
    retire(4'b0001, 1'b0, '0);
    do_fetch("beq_nt", 32'h1C, i_type(OP_BEQ, 16'hFFFF), 0, 0);
    retire(4'b0010, 1'b0, '0);

    // Jumps and priority.
    do_fetch("jr_hi", 32'h20, jr_inst(), 0, 0);
    retire(4'b1000, 1'b0, 32'h4000_0000);
    do_fetch("j", 32'h4000_0000, j_type(OP_J, 26'h10), 0, 0);
    retire(4'b0100, 1'b0, '0);
    do_fetch("jr_pri", 32'h4000_0040, jr_inst(), 0, 0);
    retire(4'b1110, 1'b1, 32'h200);
    do_fetch("j_pri", 32'h200, j_type(OP_J, 26'h100), 0, 0);
    retire(4'b0110, 1'b1, '0);

    // Delayed ack then stall with control noise; retire once stall falls.
    do_fetch("stall", 32'h400, j_type(OP_J, 26'h3FF), 0, 3);
    stall = 1'b1;
    j     = 1'b1;
    step();
    check("stall1_valid", {31'd0, o_inst_valid}, 32'd1);
    check("stall1_req", {31'd0, imem.req}, 32'd0);
    check("stall1_pc", o_pc, 32'h400);
    j         = 1'b0;
    jr        = 1'b1;
    jr_target = 32'h12;
    step();
    check("stall2_valid", {31'd0, o_inst_valid}, 32'd1);
    check("stall2_pc", o_pc, 32'h400);
    stall     = 1'b0;
    jr        = 1'b0;
    jr_target = '0;
    step();
    check("unstall_req", {31'd0, imem.req}, 32'd1);
    check("unstall_addr", imem.addr, 32'h404);
    check("unstall_valid", {31'd0, o_inst_valid}, 32'd0);

    // Reset while waiting for ack, then a late ack that must be ignored.
    step();
    check("pre_rst_addr", imem.addr, 32'h404);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, imem.req}, 32'd0);
    check("mid_rst_pc", o_pc, 32'h0);
    step();
    rst        = 1'b0;
    imem.ack   = 1'b1;
    imem.rdata = 32'h0000_0BAD;
    step();
    imem.ack   = 1'b0;
    check("late_ack_valid", {31'd0, o_inst_valid}, 32'd0);
    check("late_ack_req", {31'd0, imem.req}, 32'd1);
    check("late_ack_addr", imem.addr, 32'h0);

    // PC+4 wrap, then misaligned Jr halts.
    do_fetch("rst_f0", 32'h0, jr_inst(), 0, 0);
    retire(4'b1000, 1'b0, 32'hFFFF_FFFC);
    do_fetch("wrap", 32'hFFFF_FFFC, 32'h0, 0, 0);
    retire(4'b0000, 1'b0, '0);
    do_fetch("jr_bad", 32'h0, jr_inst(), 0, 0);
    retire(4'b1000, 1'b0, 32'h202);
    check("halt_fault", {31'd0, o_fault}, 32'd1);
    check("halt_req", {31'd0, imem.req}, 32'd0);
    check("halt_valid", {31'd0, o_inst_valid}, 32'd0);
    check("halt_pc", o_pc, 32'h0);
    imem.ack = 1'b1;
    repeat (3) step();
    imem.ack = 1'b0;
    check("halt_stay_req", {31'd0, imem.req}, 32'd0);
    check("halt_stay_fault", {31'd0, o_fault}, 32'd1);
    check("halt_stay_valid", {31'd0, o_inst_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
